// File: rtl/l2_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : l2_mem_pkg                                                 |
// | Description : Shared types and constants for the L2-to-memory arbiter:   |
// |               FSM state encoding, default tag/index widths, line width.  |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package l2_mem_pkg;

  // Tag and index together address a 26-bit line space.
  localparam int c_ADDR_W   = 26;
  localparam int c_TNUM_DEF = 22;
  localparam int c_INUM_DEF = c_ADDR_W - c_TNUM_DEF;

  // Cache line carried on every data bus.
  localparam int c_LINE_W   = 512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/l2_mem_arbiter_rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_pick2                                                   |
// | Description : Two-way round-robin pick. With a single pending requester  |
// |               it is chosen; with both pending the one that was not       |
// |               served last wins.                                          |
// | Ports       : pend[1:0] - pending flags per requester                    |
// |               last      - requester served most recently                 |
// |               grant     - chosen requester                               |
// |               valid     - at least one requester pending                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_pick2 (
  input  logic [1:0] pend,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |pend;
    if (pend == 2'b11) begin
      grant = ~last;
    end else begin
      // Only requester 1 pending selects 1; otherwise 0 (also the idle value).
      grant = pend[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : l2_mem_arbiter                                             |
// | Description : Arbitrates the instruction L2 (requester 0) and data L2    |
// |               (requester 1) onto a single memory connector. One         |
// |               transaction in flight; round-robin between requesters;    |
// |               one-cycle gap after each completion; sticky watchdog.     |
// | Ports       : clk, rstn            - clock, sync active-low reset        |
// |               reqN_read/_write     - level-held requests                 |
// |               reqN_tag/_write_tag  - read tag / write-back tag           |
// |               reqN_index           - line index                          |
// |               reqN_write_data      - write-back line                     |
// |               reqN_ready           - one-cycle completion pulse          |
// |               reqN_read_data       - returned line (held)                |
// |               mem_*                - command / data to the connector     |
// |               mem_ready            - connector completion pulse          |
// |               busy, grant_id       - transaction status                  |
// |               timeout_err          - sticky watchdog flag                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module l2_mem_arbiter
  import l2_mem_pkg::*;
#(
  parameter int TNUM    = c_TNUM_DEF,
  parameter int INUM    = c_ADDR_W - TNUM,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req0_read,
  input  logic                req0_write,
  input  logic [TNUM-1:0]     req0_tag,
  input  logic [TNUM-1:0]     req0_write_tag,
  input  logic [INUM-1:0]     req0_index,
  input  logic [c_LINE_W-1:0] req0_write_data,
  output logic                req0_ready,
  output logic [c_LINE_W-1:0] req0_read_data,
  input  logic                req1_read,
  input  logic                req1_write,
  input  logic [TNUM-1:0]     req1_tag,
  input  logic [TNUM-1:0]     req1_write_tag,
  input  logic [INUM-1:0]     req1_index,
  input  logic [c_LINE_W-1:0] req1_write_data,
  output logic                req1_ready,
  output logic [c_LINE_W-1:0] req1_read_data,
  output logic                mem_read,
  output logic                mem_write,
  output logic [TNUM-1:0]     mem_tag,
  output logic [TNUM-1:0]     mem_write_tag,
  output logic [INUM-1:0]     mem_index,
  output logic [c_LINE_W-1:0] mem_write_data,
  input  logic                mem_ready,
  input  logic [c_LINE_W-1:0] mem_read_data,
  output logic                busy,
  output logic                grant_id,
  output logic                timeout_err
);

  // Watchdog width holds values up to TIMEOUT-1 (TIMEOUT must be >= 2).
  localparam int                c_WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_ARM = c_WD_W'(TIMEOUT - 2);
  localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT - 1);
  localparam logic [c_WD_W-1:0] c_WD_ONE = c_WD_W'(1);

  state_t              r_state,     w_state_nxt;
  logic                r_last,      w_last_nxt;
  logic                r_grant_id,  w_gid_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_mem_read,  w_mem_read_nxt;
  logic                r_mem_write, w_mem_write_nxt;
  logic [TNUM-1:0]     r_tag,       w_tag_nxt;
  logic [TNUM-1:0]     r_wtag,      w_wtag_nxt;
  logic [INUM-1:0]     r_index,     w_index_nxt;
  logic [c_LINE_W-1:0] r_wdata,     w_wdata_nxt;
  logic                r_ready0,    w_ready0_nxt;
  logic                r_ready1,    w_ready1_nxt;
  logic [c_LINE_W-1:0] r_rdata0,    w_rdata0_nxt;
  logic [c_LINE_W-1:0] r_rdata1,    w_rdata1_nxt;
  logic [c_WD_W-1:0]   r_wd_cnt,    w_wd_nxt;
  logic                r_timeout_err, w_err_nxt;

  logic [1:0]          w_pend;
  logic                w_pick;
  logic                w_pick_valid;
  logic                w_sel_write;
  logic [TNUM-1:0]     w_sel_tag;
  logic [TNUM-1:0]     w_sel_wtag;
  logic [INUM-1:0]     w_sel_index;
  logic [c_LINE_W-1:0] w_sel_wdata;

  assign w_pend = {req1_read | req1_write, req0_read | req0_write};

  rr_pick2 u_rr_pick2 (
    .pend  (w_pend),
    .last  (r_last),
    .grant (w_pick),
    .valid (w_pick_valid)
  );

  // Command fields of the requester chosen this cycle. A write request
  // wins over a simultaneous read; the read stays pending for a later grant.
  assign w_sel_write = w_pick ? req1_write      : req0_write;
  assign w_sel_tag   = w_pick ? req1_tag        : req0_tag;
  assign w_sel_wtag  = w_pick ? req1_write_tag  : req0_write_tag;
  assign w_sel_index = w_pick ? req1_index      : req0_index;
  assign w_sel_wdata = w_pick ? req1_write_data : req0_write_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_last        <= 1'b1;  // requester 0 wins the first tie
      r_grant_id    <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_tag         <= '0;
      r_wtag        <= '0;
      r_index       <= '0;
      r_wdata       <= '0;
      r_ready0      <= 1'b0;
      r_ready1      <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_grant_id    <= w_gid_nxt;
      r_busy        <= w_busy_nxt;
      r_mem_read    <= w_mem_read_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_tag         <= w_tag_nxt;
      r_wtag        <= w_wtag_nxt;
      r_index       <= w_index_nxt;
      r_wdata       <= w_wdata_nxt;
      r_ready0      <= w_ready0_nxt;
      r_ready1      <= w_ready1_nxt;
      r_rdata0      <= w_rdata0_nxt;
      r_rdata1      <= w_rdata1_nxt;
      r_wd_cnt      <= w_wd_nxt;
      r_timeout_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_gid_nxt       = r_grant_id;
    w_busy_nxt      = r_busy;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_tag_nxt       = r_tag;
    w_wtag_nxt      = r_wtag;
    w_index_nxt     = r_index;
    w_wdata_nxt     = r_wdata;
    w_ready0_nxt    = 1'b0;
    w_ready1_nxt    = 1'b0;
    w_rdata0_nxt    = r_rdata0;
    w_rdata1_nxt    = r_rdata1;
    w_wd_nxt        = '0;
    w_err_nxt       = r_timeout_err;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt     = ST_BUSY;
          w_busy_nxt      = 1'b1;
          w_gid_nxt       = w_pick;
          w_mem_write_nxt = w_sel_write;
          w_mem_read_nxt  = ~w_sel_write;
          w_tag_nxt       = w_sel_tag;
          w_wtag_nxt      = w_sel_wtag;
          w_index_nxt     = w_sel_index;
          w_wdata_nxt     = w_sel_wdata;
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          // Completion: return data only for reads, pulse ready either way.
          if (r_grant_id) begin
            w_ready1_nxt = 1'b1;
            if (r_mem_read) begin
              w_rdata1_nxt = mem_read_data;
            end
          end else begin
            w_ready0_nxt = 1'b1;
            if (r_mem_read) begin
              w_rdata0_nxt = mem_read_data;
            end
          end
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_last_nxt      = r_grant_id;
          w_state_nxt     = ST_GAP;
        end else begin
          // Still waiting: count, saturating, and flag once the count
          // is about to reach TIMEOUT-1. The transaction is never aborted.
          w_wd_nxt = (r_wd_cnt == c_WD_MAX) ? r_wd_cnt : r_wd_cnt + c_WD_ONE;
          if (r_wd_cnt == c_WD_ARM) begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req0_ready     = r_ready0;
  assign req0_read_data = r_rdata0;
  assign req1_ready     = r_ready1;
  assign req1_read_data = r_rdata1;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_tag        = r_tag;
  assign mem_write_tag  = r_wtag;
  assign mem_index      = r_index;
  assign mem_write_data = r_wdata;
  assign busy           = r_busy;
  assign grant_id       = r_grant_id;
  assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_l2_mem_arbiter                                          |
// | Description : Self-checking bench for l2_mem_arbiter: directed scenarios |
// |               with literal expectations, then randomized requesters and  |
// |               memory, all compared against a transaction-level model.    |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_l2_mem_arbiter;

  localparam int TNUM = 22;
  localparam int INUM = 4;
  localparam int TO   = 64;
  localparam int LW   = 512;

  logic            clk = 1'b0;
  logic            rstn;
  logic            a_rd   [2];
  logic            a_wr   [2];
  logic [TNUM-1:0] a_tag  [2];
  logic [TNUM-1:0] a_wtag [2];
  logic [INUM-1:0] a_idx  [2];
  logic [LW-1:0]   a_wdata[2];

  logic            req0_ready, req1_ready;
  logic [LW-1:0]   req0_read_data, req1_read_data;
  logic            mem_read, mem_write;
  logic [TNUM-1:0] mem_tag, mem_write_tag;
  logic [INUM-1:0] mem_index;
  logic [LW-1:0]   mem_write_data;
  logic            mem_ready;
  logic [LW-1:0]   mem_read_data;
  logic            busy, grant_id, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  l2_mem_arbiter #(.TNUM(TNUM), .INUM(INUM), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req0_read(a_rd[0]), .req0_write(a_wr[0]), .req0_tag(a_tag[0]),
    .req0_write_tag(a_wtag[0]), .req0_index(a_idx[0]), .req0_write_data(a_wdata[0]),
    .req0_ready(req0_ready), .req0_read_data(req0_read_data),
    .req1_read(a_rd[1]), .req1_write(a_wr[1]), .req1_tag(a_tag[1]),
    .req1_write_tag(a_wtag[1]), .req1_index(a_idx[1]), .req1_write_data(a_wdata[1]),
    .req1_ready(req1_ready), .req1_read_data(req1_read_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_tag(mem_tag),
    .mem_write_tag(mem_write_tag), .mem_index(mem_index), .mem_write_data(mem_write_data),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level reference model. One transaction at a time: a request
  // seen while the bus is free becomes a command visible after that edge;
  // a completion makes the bus unavailable for one further edge before the
  // next grant can be taken.
  // ---------------------------------------------------------------------------
  bit            m_on = 0;
  bit            m_busy;
  int            m_cool;
  int            m_age;
  bit            m_last;
  bit            m_is_wr;
  logic          e_mem_read, e_mem_write, e_busy, e_gid, e_err;
  logic          e_ready0, e_ready1;
  logic [TNUM-1:0] e_tag, e_wtag;
  logic [INUM-1:0] e_idx;
  logic [LW-1:0] e_wdata, e_rdata0, e_rdata1;

  always @(posedge clk) begin
    bit p0, p1, id;
    if (!rstn) begin
      m_on = 1; m_busy = 0; m_cool = 0; m_age = 0; m_last = 1; m_is_wr = 0;
      e_mem_read = 0; e_mem_write = 0; e_busy = 0; e_gid = 0; e_err = 0;
      e_ready0 = 0; e_ready1 = 0; e_rdata0 = '0; e_rdata1 = '0;
      e_tag = '0; e_wtag = '0; e_idx = '0; e_wdata = '0;
    end else if (m_on) begin
      e_ready0 = 0;
      e_ready1 = 0;
      if (m_busy) begin
        if (mem_ready) begin
          if (e_gid) begin
            e_ready1 = 1;
            if (!m_is_wr) e_rdata1 = mem_read_data;
          end else begin
            e_ready0 = 1;
            if (!m_is_wr) e_rdata0 = mem_read_data;
          end
          m_last = e_gid; m_busy = 0; m_cool = 1;
          e_mem_read = 0; e_mem_write = 0; e_busy = 0;
        end else begin
          m_age++;
          if (m_age >= TO - 1) e_err = 1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else begin
        p0 = a_rd[0] | a_wr[0];
        p1 = a_rd[1] | a_wr[1];
        if (p0 || p1) begin
          id      = (p0 && p1) ? !m_last : p1;
          m_is_wr = a_wr[id];
          e_tag   = a_tag[id];
          e_wtag  = a_wtag[id];
          e_idx   = a_idx[id];
          e_wdata = a_wdata[id];
          e_mem_write = m_is_wr;
          e_mem_read  = !m_is_wr;
          e_gid = id; e_busy = 1; m_busy = 1; m_age = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("mem_read", mem_read, e_mem_read);
      check("mem_write", mem_write, e_mem_write);
      check("busy", busy, e_busy);
      check("timeout_err", timeout_err, e_err);
      check("req0_ready", req0_ready, e_ready0);
      check("req1_ready", req1_ready, e_ready1);
      check("req0_read_data", req0_read_data, e_rdata0);
      check("req1_read_data", req1_read_data, e_rdata1);
      if (e_busy) check("grant_id", grant_id, e_gid);
      if (e_mem_read) begin
        check("mem_tag", mem_tag, e_tag);
        check("mem_index", mem_index, e_idx);
      end
      if (e_mem_write) begin
        check("mem_write_tag", mem_write_tag, e_wtag);
        check("mem_index_wr", mem_index, e_idx);
        check("mem_write_data", mem_write_data, e_wdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit mw_on = 0;
  int mw_lat = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive one mem_ready pulse; returns at the cycle the ready pulse shows.
  task automatic mem_pulse(input logic [LW-1:0] d);
    mem_ready = 1'b1;
    mem_read_data = d;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic agent(input int n, input logic rdy);
    if (rdy) begin
      if (a_rd[n] && a_wr[n]) a_wr[n] = 1'b0;
      else begin a_rd[n] = 1'b0; a_wr[n] = 1'b0; end
    end else if (!a_rd[n] && !a_wr[n]) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0: a_rd[n] = 1'b1;
          1: a_wr[n] = 1'b1;
          default: begin a_rd[n] = 1'b1; a_wr[n] = 1'b1; end
        endcase
        a_tag[n]   = TNUM'($urandom);
        a_wtag[n]  = TNUM'($urandom);
        a_idx[n]   = INUM'($urandom);
        a_wdata[n] = rand_line();
      end
    end else begin
      if ($urandom_range(63) == 0) begin
        a_rd[n] = 1'b0;
        a_wr[n] = 1'b0;
      end else if ($urandom_range(7) == 0) begin
        a_tag[n] = TNUM'($urandom);
      end
    end
  endtask

  task automatic mem_agent();
    mem_ready = 1'b0;
    mem_read_data = rand_line();
    if (mem_read || mem_write) begin
      if (!mw_on) begin
        mw_on  = 1;
        mw_lat = ($urandom_range(39) == 0) ? 70 : int'($urandom_range(6));
      end
      if (mw_lat == 0) begin
        mem_ready = 1'b1;
        mw_on = 0;
      end else begin
        mw_lat--;
      end
    end else begin
      mw_on = 0;
      if ($urandom_range(9) == 0) mem_ready = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rstn = 1'b0;
    mem_ready = 1'b0;
    mem_read_data = '0;
    for (int i = 0; i < 2; i++) begin
      a_rd[i] = 0; a_wr[i] = 0; a_tag[i] = '0; a_wtag[i] = '0; a_idx[i] = '0; a_wdata[i] = '0;
    end
    repeat (3) tick();

    // Reset values
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_read_data", req1_read_data, '0);
    check("rst_mem_tag", mem_tag, '0);

    // Single read from requester 0, completion 40 cycles later.
    rstn = 1'b1;
    a_rd[0] = 1'b1; a_tag[0] = 22'd5; a_idx[0] = 4'd3;
    tick();
    check("t1_mem_read", mem_read, 1'b1);
    check("t1_mem_tag", mem_tag, 22'd5);
    check("t1_mem_index", mem_index, 4'd3);
    check("t1_grant_id", grant_id, 1'b0);
    repeat (38) tick();
    mem_pulse({64{8'hA5}});
    check("t1_ready", req0_ready, 1'b1);
    check("t1_read_data", req0_read_data, {64{8'hA5}});
    a_rd[0] = 1'b0;
    tick();
    check("t1_ready_once", req0_ready, 1'b0);
    check("t1_mem_read_low", mem_read, 1'b0);

    // Simultaneous reads right after reset: 0 first, 1 two cycles after ready.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    a_rd[0] = 1'b1; a_tag[0] = 22'h11;
    a_rd[1] = 1'b1; a_tag[1] = 22'h22;
    tick();
    check("t2_first_gid", grant_id, 1'b0);
    check("t2_first_tag", mem_tag, 22'h11);
    repeat (3) tick();
    mem_pulse({64{8'h5A}});
    check("t2_ready0", req0_ready, 1'b1);
    a_rd[0] = 1'b0;
    tick();
    check("t2_gap_cmd", mem_read, 1'b0);
    tick();
    check("t2_second_cmd", mem_read, 1'b1);
    check("t2_second_gid", grant_id, 1'b1);
    check("t2_second_tag", mem_tag, 22'h22);
    mem_pulse({64{8'h3C}});
    check("t2_ready1", req1_ready, 1'b1);
    check("t2_rdata1", req1_read_data, {64{8'h3C}});
    check("t2_rdata0_kept", req0_read_data, {64{8'h5A}});
    a_rd[1] = 1'b0;
    repeat (3) tick();

    // Read and write together: write goes first, read follows.
    a_rd[1] = 1'b1; a_wr[1] = 1'b1; a_tag[1] = 22'd9; a_wtag[1] = 22'd7;
    a_wdata[1] = {16{32'hDEADBEEF}};
    tick();
    check("t3_mem_write", mem_write, 1'b1);
    check("t3_mem_read", mem_read, 1'b0);
    check("t3_write_tag", mem_write_tag, 22'd7);
    check("t3_write_data", mem_write_data, {16{32'hDEADBEEF}});
    repeat (2) tick();
    mem_pulse({64{8'hFF}});
    check("t3_wr_ready", req1_ready, 1'b1);
    check("t3_rdata_kept", req1_read_data, {64{8'h3C}});
    a_wr[1] = 1'b0;
    repeat (2) tick();
    check("t3_read_next", mem_read, 1'b1);
    check("t3_read_tag", mem_tag, 22'd9);
    mem_pulse({64{8'h77}});
    a_rd[1] = 1'b0;
    repeat (3) tick();

    // Watchdog
    a_rd[0] = 1'b1; a_tag[0] = 22'h33;
    tick();
    repeat (TO - 2) tick();
    check("t4_err_before", timeout_err, 1'b0);
    tick();
    check("t4_err_at", timeout_err, 1'b1);
    repeat (5) tick();
    mem_pulse({64{8'h12}});
    a_rd[0] = 1'b0;
    repeat (3) tick();
    check("t4_err_sticky", timeout_err, 1'b1);

    // Reset in the middle of a transaction
    a_rd[1] = 1'b1; a_tag[1] = 22'h44;
    tick();
    check("t5_gid1", grant_id, 1'b1);
    repeat (2) tick();
    rstn = 1'b0;
    a_rd[0] = 1'b1; a_tag[0] = 22'h55;
    tick();
    check("t5_cmd_dropped", mem_read, 1'b0);
    check("t5_no_ready", req1_ready, 1'b0);
    check("t5_err_cleared", timeout_err, 1'b0);
    rstn = 1'b1;
    tick();
    check("t5_next_gid", grant_id, 1'b0);
    check("t5_next_tag", mem_tag, 22'h55);
    check("t5_still_no_ready", req1_ready, 1'b0);
    mem_pulse({64{8'h66}});
    a_rd[0] = 1'b0;
    repeat (2) tick();
    mem_pulse({64{8'h67}});
    a_rd[1] = 1'b0;
    repeat (3) tick();

    // Randomized traffic against the model
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      tick();
      agent(0, req0_ready);
      agent(1, req1_ready);
      mem_agent();
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin a_rd[i] = 0; a_wr[i] = 0; end
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_mem_arbiter.md
L2_MEM_ARBITER -- requirements
Module: l2_mem_arbiter

Interface
REQ-001 Parameters SHALL be: TNUM, default 22, tag width; INUM, default 26-TNUM, index width; TIMEOUT, default 1024, watchdog cycles.
REQ-002 Reset SHALL be rstn, synchronous, active-low; clock SHALL be clk.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rstn  input  1  synchronous active-low reset.
REQ-005 reqN_read, reqN_write (N=0 instruction L2, N=1 data L2)  input  1 each  level-held request until reqN_ready.
REQ-006 reqN_tag, reqN_write_tag  input  TNUM  read tag / write-back tag.
REQ-007 reqN_index  input  INUM  line index.
REQ-008 reqN_write_data  input  512  write-back line.
REQ-009 reqN_ready  output  1  one-cycle completion pulse.
REQ-010 reqN_read_data  output  512  returned line, valid with reqN_ready and held until the next completion to N.
REQ-011 mem_read, mem_write  output  1  level command to the memory connector.
REQ-012 mem_tag, mem_write_tag  output  TNUM; mem_index  output  INUM; mem_write_data  output  512.
REQ-013 mem_ready  input  1  connector completion pulse; mem_read_data  input  512  line from connector.
REQ-014 busy  output  1  high in BUSY; grant_id  output  1  requester currently served.
REQ-015 timeout_err  output  1  sticky watchdog flag.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, GAP, and no others.
REQ-017 In IDLE, a requester is pending when reqN_read or reqN_write is high; if none is pending, the FSM SHALL stay in IDLE.
REQ-018 On one pending requester, the FSM SHALL grant it; on two, it SHALL grant the requester not equal to last_grant (round-robin).
REQ-019 At the grant edge, the FSM SHALL latch op, tag, write_tag, index and write_data into command registers, set grant_id, and enter BUSY.
REQ-020 If the granted requester asserts both read and write, write SHALL be served; read is served by a later grant.
REQ-021 In BUSY, exactly one of mem_read/mem_write SHALL be high, driven from the latched command; requester input changes in BUSY SHALL be ignored.
REQ-022 On mem_ready in BUSY: copy mem_read_data to reqgrant_id_read_data, pulse reqgrant_id_ready for one cycle, drop mem_read/mem_write, set last_grant to grant_id, enter GAP (all at the same edge).
REQ-023 A write completion SHALL also pulse ready; read_data SHALL be unchanged on write completion.
REQ-024 GAP SHALL last exactly one cycle with mem commands low, then the FSM SHALL return to IDLE; request-to-command latency is 1 cycle; back-to-back grants are separated by 2 idle command cycles.
REQ-025 mem_ready in IDLE or GAP SHALL be ignored.
REQ-026 A requester dropping its request early in BUSY SHALL NOT abort the transaction; ready still pulses.
REQ-027 The watchdog counter SHALL count in BUSY and clear on leaving BUSY; reaching TIMEOUT-1 SHALL set timeout_err until reset; the transaction keeps waiting.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On reset, all outputs and command registers SHALL be 0, state SHALL be IDLE, last_grant SHALL be 1 (requester 0 wins the first tie), and the watchdog SHALL be 0.
REQ-030 Reset mid-BUSY SHALL drop mem commands at that edge with no ready pulse.

Structure
REQ-031 The package l2_mem_pkg SHALL hold the state encoding, the default TNUM/INUM, and the line width 512.
REQ-032 The round-robin pick SHALL be the sub-module rr_pick2 (inputs pend[1:0] and last; outputs grant and valid); all else is inline.

Verification
REQ-033 req0_read, tag=5, index=3; mem_ready 40 cycles later with data=A5..: mem_read high from cycle 1; req0_ready pulses once, read_data=A5...
REQ-034 req0_read and req1_read in the same cycle after reset: req0 served first, req1 granted 2 cycles after req0_ready.
REQ-035 req1_read and req1_write both high, write_tag=7: mem_write issued with mem_write_tag=7; read served next.
REQ-036 mem_ready withheld for TIMEOUT cycles: timeout_err rises at cycle TIMEOUT-1 and stays high after a later completion.
REQ-037 rstn low during BUSY: mem_read falls at that edge, no ready pulse, next grant goes to req0.
